// File: rtl/tt_um_asiclab_sum_uart_tx.sv
// -----------------------------------------------------------------------------
// tt_um_asiclab_sum_uart_tx
//
// Nibble-adder serial transmitter. A rising edge on uio_in[0] captures the
// two operand nibbles on ui_in, adds them into a 5-bit sum and sends the sum
// as an 8N1 UART frame (start, 8 data bits LSB first, stop) on uo_out[0].
//
// Ports:
//   clk      : tile clock
//   rst_n    : synchronous active-low reset
//   ena      : tile enable (always 1 when powered, ignored)
//   ui_in    : [7:4] operand A, [3:0] operand B
//   uio_in   : [0] start trigger (rising edge), [7:1] unused
//   uo_out   : [0] txd, [1] busy, [2] done pulse, [7:3] latched sum
//   uio_out  : tied 0
//   uio_oe   : tied 0 (all uio pins are inputs)
// -----------------------------------------------------------------------------
module tt_um_asiclab_sum_uart_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // Baud counter needs at least one bit even when CLKS_PER_BIT is 1.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_baud_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [4:0]      r_sum;
    logic            r_txd;
    logic            r_busy;
    logic            r_done;
    logic            r_trig_q;

    logic [4:0]      w_sum;
    logic            w_accept;
    logic            w_bit_end;
    logic            w_unused_ok;

    // Zero-extend both nibbles so the carry lands in bit 4 (max 15+15 = 30).
    assign w_sum     = {1'b0, ui_in[7:4]} + {1'b0, ui_in[3:0]};
    assign w_accept  = uio_in[0] && !r_trig_q && (r_state == IDLE);
    assign w_bit_end = (r_baud_cnt == BAUD_LAST);

    // ena and the upper uio inputs have no function in this tile.
    assign w_unused_ok = &{1'b0, ena, uio_in[7:1]};

    assign uo_out  = {r_sum, r_done, r_busy, r_txd};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // Trigger edge detect, frame sequencing and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_sum      <= 5'd0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_trig_q   <= 1'b0;
        end else begin
            r_trig_q <= uio_in[0];
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_txd <= 1'b1;
                    if (w_accept) begin
                        r_sum      <= w_sum;
                        r_shift    <= {3'b000, w_sum};
                        r_state    <= START;
                        r_txd      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_baud_cnt <= '0;
                    end else begin
                        r_baud_cnt <= '0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= 3'd0;
                        r_state    <= DATA;
                        r_txd      <= r_shift[0];
                        r_shift    <= r_shift >> 1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_txd     <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        // busy drops and done pulses on the same edge.
                        r_baud_cnt <= '0;
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_baud_cnt <= '0;
                    r_txd      <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_asiclab_sum_uart_tx.sv
// -----------------------------------------------------------------------------
// Bench for tt_um_asiclab_sum_uart_tx. Two instances: A with CLKS_PER_BIT=4,
// B with CLKS_PER_BIT=1. Stimulus pushes hand-computed expected frames into a
// per-instance queue; a monitor per instance pops one entry whenever a frame
// starts (busy rises) and compares bit stream, length, sum and completion.
// -----------------------------------------------------------------------------
module tb_tt_um_asiclab_sum_uart_tx;

    localparam int CPB_A = 4;
    localparam int CPB_B = 1;

    typedef struct packed {
        logic [4:0] sum;
        logic [9:0] frame;    // bit k = txd during bit period k
        logic       aborted;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_a, uio_a, ui_b, uio_b;
    logic [7:0] uo_a, uioo_a, oe_a, uo_b, uioo_b, oe_b;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    bit   in_fr[2];
    int   kcnt[2];
    bit   bits_ok[2];
    exp_t cur[2];
    int   done_cnt[2];

    always #5 clk = ~clk;

    tt_um_asiclab_sum_uart_tx #(.CLKS_PER_BIT(CPB_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_a), .uio_in(uio_a),
        .uo_out(uo_a), .uio_out(uioo_a), .uio_oe(oe_a)
    );

    tt_um_asiclab_sum_uart_tx #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_b), .uio_in(uio_b),
        .uo_out(uo_b), .uio_out(uioo_b), .uio_oe(oe_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Frame monitor step, evaluated once per falling edge for instance d.
    task automatic mon(input int d, input int c, input logic txd, input logic busy,
                       input logic done, input logic [4:0] sum);
        if (done) done_cnt[d]++;
        if (!in_fr[d] && busy) begin
            in_fr[d]   = 1'b1;
            kcnt[d]    = 0;
            bits_ok[d] = 1'b1;
            if ((d == 0 ? q_a.size() : q_b.size()) == 0) begin
                n_total++;
                $display("FAIL unexpected_frame dut%0d: frame started, none expected", d);
                cur[d] = '0;
            end else if (d == 0) begin
                cur[d] = q_a.pop_front();
            end else begin
                cur[d] = q_b.pop_front();
            end
        end
        if (in_fr[d]) begin
            if (busy) begin
                if (kcnt[d] < 10 * c) begin
                    if (txd !== cur[d].frame[kcnt[d] / c]) bits_ok[d] = 1'b0;
                end else begin
                    bits_ok[d] = 1'b0;
                end
                kcnt[d]++;
            end else begin
                in_fr[d] = 1'b0;
                check($sformatf("frame_aborted_dut%0d", d), 32'(!done), 32'(cur[d].aborted));
                if (done) begin
                    check($sformatf("frame_len_dut%0d", d), kcnt[d], 10 * c);
                    check($sformatf("frame_bits_dut%0d", d), 32'(bits_ok[d]), 32'd1);
                    check($sformatf("frame_sum_dut%0d", d), 32'(sum), 32'(cur[d].sum));
                end else begin
                    check($sformatf("sum_after_reset_dut%0d", d), 32'(sum), 32'd0);
                end
            end
        end
    endtask

    // Monitors: sample on the falling edge, away from the active edge.
    always @(negedge clk) mon(0, CPB_A, uo_a[0], uo_a[1], uo_a[2], uo_a[7:3]);
    always @(negedge clk) mon(1, CPB_B, uo_b[0], uo_b[1], uo_b[2], uo_b[7:3]);

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic trig_a(input logic [7:0] ui, input logic [4:0] s, input logic [9:0] f);
        ui_a = ui;
        q_a.push_back('{sum: s, frame: f, aborted: 1'b0});
        uio_a[0] = 1'b1;
        @(posedge clk);
        #1;
        uio_a[0] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if ((d == 0) ? uo_a[2] : uo_b[2]) seen = 1'b1;
        end
        if (!seen) begin
            n_total++;
            $display("FAIL done_timeout dut%0d: no done within %0d cycles", d, budget);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        ui_a  = 8'($urandom);
        uio_a = 8'($urandom);
        ui_b  = 8'($urandom);
        uio_b = 8'($urandom);
        cyc(2);
        // 1: reset state
        check("reset_uo_a", uo_a, 32'h01);
        check("reset_uo_b", uo_b, 32'h01);
        check("reset_uio_out_a", uioo_a, 32'h00);
        check("reset_uio_oe_a", oe_a, 32'h00);
        check("reset_uio_out_b", uioo_b, 32'h00);
        check("reset_uio_oe_b", oe_b, 32'h00);
        uio_a[0] = 1'b0;
        uio_b[0] = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(2);

        // 2: 3+5 = 8 -> data 0x08
        trig_a(8'h35, 5'd8, 10'b1000010000);
        check("t2_sum_latched", uo_a[7:3], 32'd8);
        check("t2_busy", uo_a[1], 32'd1);
        wait_done(0, 60);
        cyc(2);

        // 3: 15+15 = 30 -> data 0x1E
        trig_a(8'hFF, 5'd30, 10'b1000111100);
        check("t3_sum_latched", uo_a[7:3], 32'd30);
        wait_done(0, 60);
        cyc(2);

        // 4: retrigger and operand change mid-frame are ignored
        trig_a(8'h35, 5'd8, 10'b1000010000);
        cyc(9);
        ui_a     = 8'h11;
        uio_a[0] = 1'b1;
        cyc(2);
        check("t4_sum_unchanged", uo_a[7:3], 32'd8);
        uio_a[0] = 1'b0;
        wait_done(0, 60);
        cyc(5);
        // held trigger: 1+1 = 2, exactly one frame
        q_a.push_back('{sum: 5'd2, frame: 10'b1000000100, aborted: 1'b0});
        uio_a[0] = 1'b1;
        cyc(1);
        check("t4_hold_busy", uo_a[1], 32'd1);
        cyc(99);
        uio_a[0] = 1'b0;
        cyc(5);

        // 5: reset in the middle of DATA
        q_a.push_back('{sum: 5'd30, frame: 10'b1000111100, aborted: 1'b1});
        ui_a     = 8'hFF;
        uio_a[0] = 1'b1;
        cyc(1);
        uio_a[0] = 1'b0;
        cyc(20);
        rst_n = 1'b0;
        cyc(1);
        check("t5_rst_txd", uo_a[0], 32'd1);
        check("t5_rst_busy", uo_a[1], 32'd0);
        check("t5_rst_sum", uo_a[7:3], 32'd0);
        rst_n = 1'b1;
        cyc(3);
        trig_a(8'h97, 5'd16, 10'b1000100000);
        wait_done(0, 60);
        cyc(2);

        // 6: CLKS_PER_BIT=1, retrigger on the done cycle
        q_b.push_back('{sum: 5'd3, frame: 10'b1000000110, aborted: 1'b0});
        q_b.push_back('{sum: 5'd14, frame: 10'b1000011100, aborted: 1'b0});
        ui_b     = 8'h12;
        uio_b[0] = 1'b1;
        cyc(1);
        uio_b[0] = 1'b0;
        ui_b     = 8'h4A;
        wait_done(1, 30);
        uio_b[0] = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rearm_busy", uo_b[1], 32'd1);
        check("t6_rearm_sum", uo_b[7:3], 32'd14);
        uio_b[0] = 1'b0;
        wait_done(1, 30);
        cyc(50);

        // no leftover or extra frames, one done pulse per completed frame
        check("end_queue_a", q_a.size(), 32'd0);
        check("end_queue_b", q_b.size(), 32'd0);
        check("end_done_cnt_a", done_cnt[0], 32'd5);
        check("end_done_cnt_b", done_cnt[1], 32'd2);
        check("end_idle_a", 32'(in_fr[0]), 32'd0);
        check("end_idle_b", 32'(in_fr[1]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
